// File: rtl/mem_if_pkg.sv
// Shared types and constants for the lower-level memory request channel.
package mem_if_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 24;
  localparam int CNT_W  = 4;   // wide enough for LATENCY up to 15

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } resp_state_t;

endpackage

// File: rtl/lower_mem_responder_if.sv
// Request/handshake side of the cache-to-lower-level channel.
// The shared data_low tri-state net stays a plain inout on the responder so
// both bus drivers resolve onto one wire.
interface lower_mem_responder_if #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W
);
  logic              ce_low;
  logic              rw_low;
  logic [ADDR_W-1:0] addr_low;
  logic              RDY_low;
  logic              busy;

  modport master (output ce_low, rw_low, addr_low, input RDY_low, busy);
  modport slave  (input ce_low, rw_low, addr_low, output RDY_low, busy);
endinterface

// File: rtl/lower_mem_responder_sp_word_ram.sv
// Single-port synchronous word RAM: one-cycle registered read, no reset.
module sp_word_ram #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Write port wins; otherwise the addressed word is registered out.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    else    rdata    <= mem[idx];
  end
endmodule

// File: rtl/lower_mem_responder.sv
// Responder end of the four-phase lower-level memory channel. Latches one
// request, waits LATENCY cycles, completes it against the word RAM and holds
// RDY_low (and read data) until the requester drops ce_low.
module lower_mem_responder #(
  parameter int DATA_W     = mem_if_pkg::DATA_W,
  parameter int ADDR_W     = mem_if_pkg::ADDR_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int WORD_LSB   = 3,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lower_mem_responder_if.slave  bus,
  inout  wire  [DATA_W-1:0]     data_low
);
  import mem_if_pkg::*;

  resp_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;
  logic                  drv_q, drv_d;
  logic                  ram_we;
  logic [DATA_W-1:0]     rdata;

  // Aliased address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_low[ADDR_W-1:WORD_LSB+DEPTH_LOG2],
                         bus.addr_low[WORD_LSB-1:0]};

  // Commit edge of a write: last ACCESS cycle. A reset before it discards the write.
  assign ram_we = (state_q == ACCESS) && (cnt_q == '0) && (rw_q == RW_WRITE);

  sp_word_ram #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Next-state logic: request latch, latency countdown, handshake completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdy_d   = rdy_q;
    drv_d   = drv_q;
    case (state_q)
      IDLE: begin
        if (bus.ce_low) begin
          rw_d    = bus.rw_low;
          idx_d   = bus.addr_low[WORD_LSB +: DEPTH_LOG2];
          wdata_d = data_low;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // ce_low is not looked at here; a dropped request still completes.
        if (cnt_q == '0) begin
          rdy_d   = 1'b1;
          drv_d   = (rw_q == RW_READ);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (!bus.ce_low) begin
          rdy_d   = 1'b0;
          drv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset releases the bus asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_WRITE;
      idx_q   <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      drv_q   <= drv_d;
    end
  end

  assign bus.RDY_low = rdy_q;
  assign bus.busy    = (state_q != IDLE);
  assign data_low    = drv_q ? rdata : 'z;

endmodule
